// File: rtl/panel_keypad_pkg.sv
// Shared definitions for panel_keypad: command indices, scan states, helpers.
// Auto-repeat is enabled by defining KEYPAD_AUTOREPEAT_EN.
package panel_keypad_pkg;

    localparam int NUM_CMD      = 13;
    localparam int CMD_STEP     = 0;
    localparam int CMD_RESET    = 1;
    localparam int CMD_RUNHALT  = 2;
    localparam int CMD_STOREINC = 3;
    localparam int CMD_IRQ      = 4;
    localparam int CMD_DEC      = 5;
    localparam int CMD_LOAD     = 6;
    localparam int CMD_TOA      = 7;
    localparam int CMD_TOSP     = 8;
    localparam int CMD_TOX      = 9;
    localparam int CMD_TOY      = 10;
    localparam int CMD_TOPC     = 11;
    localparam int CMD_CLR      = 12;

    typedef enum logic [1:0] {
        ST_SCAN  = 2'd0,
        ST_PRESS = 2'd1,
        ST_HELD  = 2'd2
    } scan_state_e;

    function automatic logic [1:0] lowest_low(input logic [3:0] n);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!n[i]) r = 2'(i);
        end
        return r;
    endfunction

    function automatic logic [NUM_CMD-1:0] lowest_one(
        input logic [NUM_CMD-1:0] v
    );
        logic [NUM_CMD-1:0] r;
        r = '0;
        for (int i = 0; i < NUM_CMD; i++) begin
            if (v[i] && (r == '0)) r[i] = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/panel_keypad_key_debounce.sv
// One command button: 2-flop sync, stable-level debounce, accepted-press strobe.
// The held output exists only when KEYPAD_AUTOREPEAT_EN is defined.
module panel_keypad_key_debounce #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
`ifdef KEYPAD_AUTOREPEAT_EN
    output logic held,
`endif
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          stable_q, stable_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // cnt_q counts consecutive cycles the synced input disagrees with stable_q
    always_comb begin
        sync1_d  = key_n;
        sync2_d  = sync1_q;
        stable_d = stable_q;
        cnt_d    = '0;
        press    = 1'b0;
        if (sync2_q != stable_q) begin
            if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
                stable_d = sync2_q;
                press    = ~sync2_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q  <= 1'b1;
            sync2_q  <= 1'b1;
            stable_q <= 1'b1;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

`ifdef KEYPAD_AUTOREPEAT_EN
    assign held = ~stable_q;
`endif

endmodule

// File: rtl/panel_keypad.sv
// Front-panel encoder: 4x4 hex keypad scan, hex entry, 13 debounced commands.
// Define KEYPAD_AUTOREPEAT_EN to auto-repeat STOREINC and DEC while held.
module panel_keypad
    import panel_keypad_pkg::*;
#(
    parameter int SCAN_DIV        = 64,
    parameter int DEBOUNCE_CYCLES = 50000
`ifdef KEYPAD_AUTOREPEAT_EN
  , parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_RATE     = 5000000
`endif
) (
    input  logic        clk,
    input  logic        rst,
    output logic [3:0]  row_n,
    input  logic [3:0]  col_n,
    input  logic [12:0] cmd_n,
    output logic [15:0] user_input,
    output logic        input_valid,
    output logic [2:0]  digit_count,
    output logic [12:0] cmd_pulse
);

    localparam int DW = $clog2(SCAN_DIV + 1);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [3:0]         col_s1_q, col_s1_d;
    logic [3:0]         col_s_q, col_s_d;
    scan_state_e        state_q, state_d;
    logic [1:0]         row_idx_q, row_idx_d;
    logic [1:0]         col_idx_q, col_idx_d;
    logic [DW-1:0]      div_q, div_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [3:0]         row_n_q, row_n_d;
    logic               digit_evt;

    logic [15:0]        entry_q, entry_d;
    logic [2:0]         digit_count_q, digit_count_d;
    logic [NUM_CMD-1:0] pending_q, pending_d;
    logic [NUM_CMD-1:0] cmd_pulse_q, cmd_pulse_d;
    logic [NUM_CMD-1:0] cmd_press;
    logic [NUM_CMD-1:0] rpt_req;
    logic [NUM_CMD-1:0] req;
    logic [15:0]        entry_base;
    logic [2:0]         count_base;

`ifdef KEYPAD_AUTOREPEAT_EN
    logic [NUM_CMD-1:0] cmd_held;
`endif

    for (genvar i = 0; i < NUM_CMD; i++) begin : g_cmd
        panel_keypad_key_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_db (
            .clk   (clk),
            .rst   (rst),
            .key_n (cmd_n[i]),
`ifdef KEYPAD_AUTOREPEAT_EN
            .held  (cmd_held[i]),
`endif
            .press (cmd_press[i])
        );
    end

    always_comb begin
        col_s1_d  = col_n;
        col_s_d   = col_s1_q;
        state_d   = state_q;
        row_idx_d = row_idx_q;
        col_idx_d = col_idx_q;
        div_d     = div_q;
        cnt_d     = cnt_q;
        digit_evt = 1'b0;
        unique case (state_q)
            ST_SCAN: begin
                if (div_q == DW'(SCAN_DIV - 1)) begin
                    div_d = '0;
                    if (&col_s_q) begin
                        row_idx_d = row_idx_q + 2'd1;
                    end else begin
                        col_idx_d = lowest_low(col_s_q);
                        cnt_d     = '0;
                        state_d   = ST_PRESS;
                    end
                end else begin
                    div_d = div_q + DW'(1);
                end
            end
            ST_PRESS: begin
                if (col_s_q[col_idx_q]) begin
                    state_d = ST_SCAN;
                    div_d   = '0;
                end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
                    digit_evt = 1'b1;
                    cnt_d     = '0;
                    state_d   = ST_HELD;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_HELD: begin
                if (!col_s_q[col_idx_q]) begin
                    cnt_d = '0;
                end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
                    cnt_d     = '0;
                    div_d     = '0;
                    row_idx_d = row_idx_q + 2'd1;
                    state_d   = ST_SCAN;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = ST_SCAN;
            end
        endcase
        row_n_d = ~(4'b0001 << row_idx_d);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_s1_q  <= 4'hF;
            col_s_q   <= 4'hF;
            state_q   <= ST_SCAN;
            row_idx_q <= 2'd0;
            col_idx_q <= 2'd0;
            div_q     <= '0;
            cnt_q     <= '0;
            row_n_q   <= 4'hF;
        end else begin
            col_s1_q  <= col_s1_d;
            col_s_q   <= col_s_d;
            state_q   <= state_d;
            row_idx_q <= row_idx_d;
            col_idx_q <= col_idx_d;
            div_q     <= div_d;
            cnt_q     <= cnt_d;
            row_n_q   <= row_n_d;
        end
    end

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int RPT_MAX =
        (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RW = $clog2(RPT_MAX + 1);

    logic [1:0] rpt_hit;

    // Timer restarts on every pulse of the key, so repeats are spaced from pulses
    for (genvar g = 0; g < 2; g++) begin : g_rpt
        localparam int IDX = (g == 0) ? CMD_STOREINC : CMD_DEC;
        logic [RW-1:0] rpt_cnt_q, rpt_cnt_d;
        logic          run_q, run_d;
        logic          first_q, first_d;
        logic [RW-1:0] limit;
        logic          hit;

        always_comb begin
            limit     = first_q ? RW'(REPEAT_DELAY - 1)
                                : RW'(REPEAT_RATE - 1);
            rpt_cnt_d = rpt_cnt_q;
            run_d     = run_q;
            first_d   = first_q;
            hit       = 1'b0;
            if (!cmd_held[IDX]) begin
                run_d   = 1'b0;
                first_d = 1'b1;
            end else if (cmd_pulse_q[IDX]) begin
                run_d     = 1'b1;
                rpt_cnt_d = RW'(1);
            end else if (run_q) begin
                if (rpt_cnt_q == limit) begin
                    hit     = 1'b1;
                    run_d   = 1'b0;
                    first_d = 1'b0;
                end else begin
                    rpt_cnt_d = rpt_cnt_q + RW'(1);
                end
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                rpt_cnt_q <= '0;
                run_q     <= 1'b0;
                first_q   <= 1'b1;
            end else begin
                rpt_cnt_q <= rpt_cnt_d;
                run_q     <= run_d;
                first_q   <= first_d;
            end
        end

        assign rpt_hit[g] = hit;
    end

    always_comb begin
        rpt_req               = '0;
        rpt_req[CMD_STOREINC] = rpt_hit[0];
        rpt_req[CMD_DEC]      = rpt_hit[1];
    end
`else
    assign rpt_req = '0;
`endif

    // The entry survives the pulse cycle so the consumer can sample it
    always_comb begin
        req         = pending_q | cmd_press | rpt_req;
        cmd_pulse_d = lowest_one(req);
        pending_d   = req & ~cmd_pulse_d;
        entry_base  = (|cmd_pulse_q) ? 16'h0 : entry_q;
        count_base  = (|cmd_pulse_q) ? 3'd0 : digit_count_q;
        entry_d       = entry_base;
        digit_count_d = count_base;
        if (digit_evt) begin
            entry_d       = {entry_base[11:0], row_idx_q, col_idx_q};
            digit_count_d = (count_base == 3'd4) ? 3'd4
                                                 : count_base + 3'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            entry_q       <= 16'h0;
            digit_count_q <= 3'd0;
            pending_q     <= '0;
            cmd_pulse_q   <= '0;
        end else begin
            entry_q       <= entry_d;
            digit_count_q <= digit_count_d;
            pending_q     <= pending_d;
            cmd_pulse_q   <= cmd_pulse_d;
        end
    end

    assign row_n       = row_n_q;
    assign user_input  = entry_q;
    assign digit_count = digit_count_q;
    assign input_valid = (digit_count_q != 3'd0);
    assign cmd_pulse   = cmd_pulse_q;

endmodule

// File: tb/tb_panel_keypad.sv
// Self-checking bench for panel_keypad: keypad entry table, command timing,
// corner sequences and a randomized command run against a scheduling model.
module tb_panel_keypad;
    import panel_keypad_pkg::*;

    localparam int SD = 8;
    localparam int DB = 4;
`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int RD = 40;
    localparam int RR = 10;
`endif
    localparam int RN = 2000;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  row_n;
    logic [3:0]  col_n;
    logic [12:0] cmd_n;
    logic [15:0] user_input;
    logic        input_valid;
    logic [2:0]  digit_count;
    logic [12:0] cmd_pulse;

    logic        key_down;
    logic [3:0]  key_code;
    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;

    typedef struct {
        logic [3:0]  key;
        logic [15:0] exp_in;
        logic [2:0]  exp_cnt;
    } kvec_t;

    panel_keypad #(
        .SCAN_DIV(SD),
        .DEBOUNCE_CYCLES(DB)
`ifdef KEYPAD_AUTOREPEAT_EN
      , .REPEAT_DELAY(RD),
        .REPEAT_RATE(RR)
`endif
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .row_n       (row_n),
        .col_n       (col_n),
        .cmd_n       (cmd_n),
        .user_input  (user_input),
        .input_valid (input_valid),
        .digit_count (digit_count),
        .cmd_pulse   (cmd_pulse)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Keypad matrix: pressed key pulls its column low while its row is driven
    always_comb begin
        col_n = 4'hF;
        if (key_down && !row_n[key_code[3:2]]) col_n[key_code[1:0]] = 1'b0;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press_key(input logic [3:0] code);
        key_code = code;
        key_down = 1'b1;
        tick(70);
        key_down = 1'b0;
        tick(60);
    endtask

    task automatic wait_row(input logic [1:0] r, output bit ok);
        logic [3:0] prev;
        logic [3:0] want;
        logic [3:0] one;
        one  = 4'b0001;
        want = ~(one << r);
        ok   = 1'b0;
        prev = row_n;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(posedge clk);
            #1;
            if (row_n == want && prev != want) ok = 1'b1;
            prev = row_n;
        end
    endtask

    function automatic logic [12:0] lowest_bit(input logic [12:0] v);
        for (int i = 0; i < 13; i++) begin
            if (v[i]) return 13'(1 << i);
        end
        return 13'd0;
    endfunction

    kvec_t       tbl[5];
    bit          ok;
    int          n0;
    int          k;
    bit          rpt;
    logic [12:0] exp_p;
    logic [12:0] pend;
    logic [12:0] arr[0:RN+31];
    int          timer[13];
    bit          down[13];

    initial begin
        tbl[0] = '{4'h1, 16'h0001, 3'd1};
        tbl[1] = '{4'h2, 16'h0012, 3'd2};
        tbl[2] = '{4'hA, 16'h012A, 3'd3};
        tbl[3] = '{4'hB, 16'h12AB, 3'd4};
        tbl[4] = '{4'h5, 16'h2AB5, 3'd4};

        rst      = 1'b1;
        cmd_n    = 13'h1FFF;
        key_down = 1'b0;
        key_code = 4'h0;
        tick(3);
        chk("rst_row_n", row_n, 4'hF);
        chk("rst_user_input", user_input, 16'h0);
        chk("rst_valid", input_valid, 1'b0);
        chk("rst_count", digit_count, 3'd0);
        chk("rst_pulse", cmd_pulse, 13'h0);
        rst = 1'b0;
        tick(5);

        for (int i = 0; i < 5; i++) begin
            press_key(tbl[i].key);
            chk("entry_value", user_input, tbl[i].exp_in);
            chk("entry_count", digit_count, tbl[i].exp_cnt);
            chk("entry_valid", input_valid, 1'b1);
        end

        @(posedge clk);
        #1;
        cmd_n[CMD_LOAD] = 1'b0;
        n0 = cyc;
        for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            k = cyc - n0;
            chk("load_pulse", cmd_pulse,
                (k == 6) ? 13'(1 << CMD_LOAD) : 13'd0);
            if (k == 6) chk("load_entry_shown", user_input, 16'h2AB5);
            if (k == 7) begin
                chk("load_entry_clr", user_input, 16'h0);
                chk("load_valid_clr", input_valid, 1'b0);
                chk("load_count_clr", digit_count, 3'd0);
            end
        end
        tick(1);
        cmd_n = 13'h1FFF;
        tick(20);

        key_code = 4'hE;
        wait_row(2'd3, ok);
        chk("bounce_row_wait", ok, 1'b1);
        key_down = 1'b1;
        tick(8);
        key_down = 1'b0;
        tick(40);
        chk("bounce_no_digit", digit_count, 3'd0);
        chk("bounce_no_entry", user_input, 16'h0);
        wait_row(2'd0, ok);
        chk("bounce_scan_resumes", ok, 1'b1);

        @(posedge clk);
        #1;
        cmd_n[CMD_TOX]  = 1'b0;
        cmd_n[CMD_STEP] = 1'b0;
        n0 = cyc;
        for (int j = 0; j < 40; j++) begin
            @(negedge clk);
            k = cyc - n0;
            exp_p = (k == 6) ? 13'(1 << CMD_STEP) :
                    (k == 7) ? 13'(1 << CMD_TOX) : 13'd0;
            chk("step_tox_pulse", cmd_pulse, exp_p);
        end
        tick(1);
        cmd_n = 13'h1FFF;
        tick(20);

        @(posedge clk);
        #1;
        cmd_n[CMD_STOREINC] = 1'b0;
        n0 = cyc;
        for (int j = 0; j < 100; j++) begin
            @(negedge clk);
            k = cyc - n0;
`ifdef KEYPAD_AUTOREPEAT_EN
            rpt = (k >= 6 + RD) && ((k - 6 - RD) % RR == 0);
`else
            rpt = 1'b0;
`endif
            exp_p = ((k == 6) || rpt) ? 13'(1 << CMD_STOREINC) : 13'd0;
            chk("storeinc_pulse", cmd_pulse, exp_p);
        end
        tick(1);
        cmd_n = 13'h1FFF;
        for (int j = 0; j < 50; j++) begin
            @(negedge clk);
            k = cyc - n0;
            if (k >= 110) chk("storeinc_after_release", cmd_pulse, 13'd0);
        end
        tick(10);

        press_key(4'h3);
        press_key(4'h4);
        press_key(4'h7);
        chk("pre_rst_entry", user_input, 16'h0347);
        chk("pre_rst_count", digit_count, 3'd3);
        key_code = 4'h9;
        wait_row(2'd2, ok);
        chk("rst_row_wait", ok, 1'b1);
        key_down = 1'b1;
        tick(9);
        rst = 1'b1;
        #1;
        chk("midrst_row_n", row_n, 4'hF);
        chk("midrst_entry", user_input, 16'h0);
        chk("midrst_valid", input_valid, 1'b0);
        chk("midrst_count", digit_count, 3'd0);
        chk("midrst_pulse", cmd_pulse, 13'h0);
        tick(2);
        rst = 1'b0;
        tick(100);
        chk("redebounce_entry", user_input, 16'h0009);
        chk("redebounce_count", digit_count, 3'd1);
        key_down = 1'b0;
        tick(60);

        for (int i = 0; i < RN + 32; i++) arr[i] = 13'd0;
        for (int i = 0; i < 13; i++) begin
            down[i]  = 1'b0;
            timer[i] = int'($urandom_range(0, 20));
        end
        pend = 13'd0;
        for (int r = 0; r < RN; r++) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 13; i++) begin
                if (timer[i] == 0) begin
                    down[i]  = ~down[i];
                    cmd_n[i] = ~down[i];
                    if (down[i]) arr[r + DB + 2][i] = 1'b1;
                    timer[i] = int'($urandom_range(6, 20));
                end else begin
                    timer[i]--;
                end
            end
            @(negedge clk);
            pend  = pend | arr[r];
            exp_p = lowest_bit(pend);
            pend  = pend & ~exp_p;
            chk("rand_pulse", cmd_pulse, exp_p);
        end
        tick(1);
        cmd_n = 13'h1FFF;
        tick(40);
        chk("final_idle_pulse", cmd_pulse, 13'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
